fetch_aligner: RTL and testbench
================================

# fetch_aligner

Halfword-granular fetch buffer and instruction aligner between the fetch unit and the decoders. Accepts fixed-size fetch packets of mixed 16/32-bit RISC-V instructions and stores them as a halfword queue. Each cycle it presents up to ISSUE whole, aligned instructions, one per decoder lane, and carries instructions that straddle packet boundaries over to the next packet. Instruction-start detection reuses the existing `segment` block, applied to the head window of the queue.

## Interface
- `WIDTH`, 4: words per fetch packet; a packet holds DW = 2*WIDTH halfwords.
- `ISSUE`, 4: decoder lanes, i.e. maximum instructions presented per cycle.
- `DEPTH`, 24: queue capacity in halfwords. Must satisfy DEPTH >= DW + 2*ISSUE.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_flush`  in  1  discard all buffered halfwords (redirect).
- `i_packet`  in  32*WIDTH  fetch packet; halfword 0 is in the LSBs.
- `i_offset`  in  $clog2(DW)  number of leading halfwords of `i_packet` to drop (redirect target inside the packet).
- `i_packet_valid`  in  1  packet present.
- `o_packet_ready`  out  1  queue can accept a packet this cycle.
- `o_inst`  out  32*ISSUE  lane k occupies bits [32k+31:32k]; compressed instructions have the upper half zeroed.
- `o_inst_valid`  out  ISSUE  thermometer code: lane k valid implies lanes 0..k-1 valid.
- `o_compressed`  out  ISSUE  per-lane flag, set when the lane holds a 16-bit instruction.
- `i_inst_ready`  in  1  decoders take all valid lanes this cycle.

## Operation
- State: halfword array `q[DEPTH]` with the head always at index 0 (compacting shift queue), and occupancy `occ` in the range 0..DEPTH.
- Window: halfwords q[0..2*ISSUE-1] feed `segment` (WIDTH=ISSUE), which produces start flags `s[2*ISSUE]`. A halfword is compressed when its bits [1:0] != 2'b11.
- Lane k holds the k-th set start flag. Its position p_k is the sum of the sizes of lanes 0..k-1 (16-bit = 1 halfword, 32-bit = 2 halfwords).
- Lane k is valid when p_k + size_k <= occ, lanes 0..k-1 are valid, and i_flush is 0.
  - A 32-bit instruction whose upper halfword has not yet arrived is withheld. It is not emitted in part.
- Pop: when i_inst_ready is 1, pop = sum of the sizes of the valid lanes; otherwise pop = 0. The queue shifts down by pop halfwords.
- Push: a packet is accepted when i_packet_valid and o_packet_ready are both 1.
  - Halfwords i_offset..DW-1 are written starting at q[occ - pop].
  - occ_next = occ - pop + (DW - i_offset).
- o_packet_ready = !i_rst && !i_flush && (occ <= DEPTH - DW). It depends only on registered occ, so there is no combinational path from i_inst_ready.
- Flush: occ_next = 0. The same-cycle packet is not accepted (ready is 0), and no lane is valid.
- Reset: occ = 0. Queue contents are don't-care.
  - During and after reset: o_inst_valid = 0 and o_compressed = 0.
  - o_packet_ready is 0 while i_rst is high and 1 in the first cycle after reset.
- Reset or flush in the middle of a straddled instruction discards the partial instruction.
- Simultaneous push, pop and a full queue are legal. Ready is evaluated on pre-pop occ, which is conservative.

## Timing
- Packet accepted at edge N: its halfwords are visible at lane outputs in cycle N+1 if they are at the head. This is one cycle of latency.
- Lane outputs are combinational from registered state and carry no input-to-output path, except that i_flush gates o_inst_valid.
- Steady-state throughput is one packet per cycle when the decoders keep up. With ISSUE >= DW, all-compressed code sustains the full rate.
- occ arithmetic uses $clog2(DEPTH+1) bits and never wraps. This is guaranteed by the ready rule and the DEPTH constraint.

## Structure
- Shared package holds: localparams WORD=32 and HALF=16; a function `is_compressed(halfword)`; a function `inst_halves(halfword)` that returns 1 or 2.
- Sub-modules:
  - `segment` is instantiated for start detection.
  - A small combinational sub-module `lane_select` computes p_k, lane validity and lane extraction from the window and occ, which keeps the sequential top compact.

## Test plan
- Reset, then push a packet of 8 compressed halfwords (0x0001 each) with ISSUE=4:
  - cycle 1: lanes 0-3 valid, o_compressed=4'b1111, pop 4;
  - cycle 2: remaining 4 valid;
  - then o_inst_valid=0.
- Straddle: packet A has 7 compressed halfwords followed by the low half 0x0013 of an `addi`; packet B follows a cycle late with upper half 0x0000.
  - Until B arrives, that instruction stays invalid.
  - Once B arrives, lane 0 = 0x00000013 with o_compressed[0]=0.
- Offset: packet with i_offset=3 -> first emitted lane is halfword 3 of the packet, and occ grows by 5.
- Backpressure: hold i_inst_ready=0 while streaming packets.
  - o_packet_ready drops when occ > DEPTH-DW (occ=24 after 3 packets at the defaults).
  - No data is lost, and order is preserved after release.
- Flush in the same cycle as i_packet_valid with a half-buffered 32-bit instruction:
  - o_packet_ready=0 and o_inst_valid=0 in that cycle;
  - occ=0 on the next cycle;
  - the next packet emits from its own halfword 0.
- Assert i_rst mid-stream -> outputs go to 0 on the next edge, and o_packet_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/fetch_aligner_pkg.sv
// Shared constants and instruction-size helpers for the fetch aligner.
package fetch_aligner_pkg;

    localparam int unsigned WORD = 32;
    localparam int unsigned HALF = 16;

    // A halfword starts a 16-bit instruction unless its two LSBs are both set.
    function automatic logic is_compressed(input logic [HALF-1:0] hw);
        return (hw & HALF'(3)) != HALF'(3);
    endfunction

    // Instruction length in halfwords for an instruction starting at hw.
    function automatic logic [1:0] inst_halves(input logic [HALF-1:0] hw);
        return is_compressed(hw) ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/lane_select.sv
// Maps start flags to decoder lanes, checks completeness against occupancy, extracts lanes.
module lane_select
    import fetch_aligner_pkg::*;
#(
    parameter int unsigned ISSUE = 4,
    parameter int unsigned OCCW  = 5,
    parameter int unsigned PW    = 4
) (
    input  logic [2*ISSUE*HALF-1:0] win,
    input  logic [2*ISSUE-1:0]      start,
    input  logic [2*ISSUE-1:0]      comp,
    input  logic [OCCW-1:0]         occ,
    input  logic                    en,
    output logic [WORD*ISSUE-1:0]   inst,
    output logic [ISSUE-1:0]        valid,
    output logic [ISSUE-1:0]        compressed,
    output logic [PW-1:0]           pop
);

    localparam int unsigned WIN = 2*ISSUE;
    localparam int unsigned LW  = (ISSUE > 1) ? $clog2(ISSUE) : 1;

    logic [HALF-1:0] hw    [WIN+1];
    logic [WORD-1:0] lanes [ISSUE];
    int              lane;
    int              used;
    int              size;
    logic            chain;

    // Unpack the window; the extra zero halfword keeps hw[i+1] in range.
    always_comb begin
        for (int j = 0; j < int'(WIN); j++) begin
            hw[j] = win[j*HALF +: HALF];
        end
        hw[WIN] = '0;
    end

    // Lane k takes the k-th start; it is valid only if whole and all earlier lanes are valid.
    always_comb begin
        valid      = '0;
        compressed = '0;
        lane       = 0;
        used       = 0;
        size       = 0;
        chain      = en;
        for (int k = 0; k < int'(ISSUE); k++) begin
            lanes[k] = '0;
        end
        for (int i = 0; i < int'(WIN); i++) begin
            if (start[i] && (lane < int'(ISSUE))) begin
                size = comp[i] ? 1 : 2;
                if (chain && ((i + size) <= int'(occ))) begin
                    valid[LW'(lane)]      = 1'b1;
                    compressed[LW'(lane)] = comp[i];
                    lanes[LW'(lane)]      = comp[i] ? {HALF'(0), hw[i]} : {hw[i+1], hw[i]};
                    used                  = used + size;
                end else begin
                    chain = 1'b0;
                end
                lane = lane + 1;
            end
        end
        pop = PW'(used);
    end

    // Pack lanes onto the output bus.
    always_comb begin
        inst = '0;
        for (int k = 0; k < int'(ISSUE); k++) begin
            inst[k*WORD +: WORD] = lanes[k];
        end
    end

endmodule

// File: rtl/segment.sv
// Instruction-start detection over a window of 2*WIDTH halfwords.
module segment
    import fetch_aligner_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [2*WIDTH*HALF-1:0] win,
    output logic [2*WIDTH-1:0]      start,
    output logic [2*WIDTH-1:0]      comp
);

    logic prev;

    // Halfword 0 always starts; a 32-bit start suppresses the next halfword.
    always_comb begin
        start = '0;
        comp  = '0;
        prev  = 1'b1;
        for (int i = 0; i < int'(2*WIDTH); i++) begin
            comp[i]  = inst_halves(win[i*HALF +: HALF]) == 2'd1;
            start[i] = prev;
            prev     = !prev || comp[i];
        end
    end

endmodule

// File: rtl/fetch_aligner.sv
// Halfword fetch queue that aligns mixed 16/32-bit instructions onto decoder lanes.
module fetch_aligner
    import fetch_aligner_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ISSUE = 4,
    parameter int unsigned DEPTH = 24
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_flush,
    input  logic [WORD*WIDTH-1:0]     i_packet,
    input  logic [$clog2(2*WIDTH)-1:0] i_offset,
    input  logic                      i_packet_valid,
    output logic                      o_packet_ready,
    output logic [WORD*ISSUE-1:0]     o_inst,
    output logic [ISSUE-1:0]          o_inst_valid,
    output logic [ISSUE-1:0]          o_compressed,
    input  logic                      i_inst_ready
);

    localparam int unsigned DW   = 2*WIDTH;
    localparam int unsigned OFFW = $clog2(DW);
    localparam int unsigned OCCW = $clog2(DEPTH+1);
    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam int unsigned WIN  = 2*ISSUE;
    localparam int unsigned PW   = $clog2(WIN+1);

    logic [OCCW-1:0]     occ;
    logic [HALF-1:0]     q     [DEPTH];
    logic [HALF-1:0]     q_n   [DEPTH];
    logic [HALF-1:0]     pkt_h [DW];
    logic [WIN*HALF-1:0] win;
    logic [WIN-1:0]      start;
    logic [WIN-1:0]      comp;
    logic [PW-1:0]       lane_pop;
    logic                en;
    logic                push;
    int                  pop_i;
    int                  base_i;
    int                  cnt_i;
    int                  occ_n_i;

    assign o_packet_ready = !i_rst && !i_flush && (occ <= OCCW'(DEPTH - DW));
    assign push           = i_packet_valid && o_packet_ready;
    assign en             = !i_rst && !i_flush;

    // Head window of the queue and the incoming packet split into halfwords.
    always_comb begin
        win = '0;
        for (int j = 0; j < int'(WIN); j++) begin
            win[j*HALF +: HALF] = q[j];
        end
        for (int j = 0; j < int'(DW); j++) begin
            pkt_h[j] = i_packet[j*HALF +: HALF];
        end
    end

    segment #(
        .WIDTH (ISSUE)
    ) u_segment (
        .win   (win),
        .start (start),
        .comp  (comp)
    );

    lane_select #(
        .ISSUE (ISSUE),
        .OCCW  (OCCW),
        .PW    (PW)
    ) u_lane_select (
        .win        (win),
        .start      (start),
        .comp       (comp),
        .occ        (occ),
        .en         (en),
        .inst       (o_inst),
        .valid      (o_inst_valid),
        .compressed (o_compressed),
        .pop        (lane_pop)
    );

    // Shift out popped halfwords and append the accepted packet behind the survivors.
    always_comb begin
        pop_i   = i_inst_ready ? int'(lane_pop) : 0;
        base_i  = int'(occ) - pop_i;
        cnt_i   = int'(DW) - int'(i_offset);
        occ_n_i = base_i + (push ? cnt_i : 0);
        for (int j = 0; j < int'(DEPTH); j++) begin
            if (push && (j >= base_i) && (j < base_i + cnt_i)) begin
                q_n[j] = pkt_h[OFFW'(j - base_i + int'(i_offset))];
            end else if ((j + pop_i) < int'(DEPTH)) begin
                q_n[j] = q[IDXW'(j + pop_i)];
            end else begin
                q_n[j] = q[j];
            end
        end
    end

    // Occupancy; reset and flush both empty the queue.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            occ <= '0;
        end else begin
            occ <= OCCW'(occ_n_i);
        end
    end

    // Queue storage; contents beyond occ are don't-care so no reset is needed.
    always_ff @(posedge i_clk) begin
        for (int j = 0; j < int'(DEPTH); j++) begin
            q[j] <= q_n[j];
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// Scoreboard bench for fetch_aligner against a halfword-queue reference model.
module tb_fetch_aligner;

    localparam int WIDTH = 4;
    localparam int ISSUE = 4;
    localparam int DEPTH = 24;
    localparam int DW    = 2*WIDTH;

    typedef struct packed {
        logic         rdy;
        logic [3:0]   v;
        logic [3:0]   c;
        logic [127:0] inst;
    } exp_t;

    logic         clk;
    logic         i_rst;
    logic         i_flush;
    logic [127:0] i_packet;
    logic [2:0]   i_offset;
    logic         i_packet_valid;
    logic         o_packet_ready;
    logic [127:0] o_inst;
    logic [3:0]   o_inst_valid;
    logic [3:0]   o_compressed;
    logic         i_inst_ready;

    exp_t        exp_q[$];
    logic [15:0] mq[$];
    int          total = 0;
    int          bad   = 0;

    fetch_aligner #(
        .WIDTH (WIDTH),
        .ISSUE (ISSUE),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_flush        (i_flush),
        .i_packet       (i_packet),
        .i_offset       (i_offset),
        .i_packet_valid (i_packet_valid),
        .o_packet_ready (o_packet_ready),
        .o_inst         (o_inst),
        .o_inst_valid   (o_inst_valid),
        .o_compressed   (o_compressed),
        .i_inst_ready   (i_inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, want);
        end
    endtask

    // One cycle: drive inputs, predict outputs from the model, then advance the model past the edge.
    task automatic step(input logic rst, input logic fl, input logic pv,
                        input logic [127:0] pkt, input logic [2:0] off, input logic ir);
        exp_t        e;
        int          pos;
        int          sz;
        logic [15:0] h;
        @(negedge clk);
        i_rst = rst; i_flush = fl; i_packet_valid = pv;
        i_packet = pkt; i_offset = off; i_inst_ready = ir;
        e = '0;
        pos = 0;
        e.rdy = !rst && !fl && (mq.size() <= DEPTH - DW);
        if (!rst && !fl) begin
            for (int k = 0; k < ISSUE; k++) begin
                if (pos >= mq.size()) break;
                h  = mq[pos];
                sz = (h[1:0] == 2'b11) ? 2 : 1;
                if (pos + sz > mq.size()) break;
                e.v[k] = 1'b1;
                e.c[k] = (sz == 1);
                e.inst[k*32 +: 32] = (sz == 1) ? {16'h0000, h} : {mq[pos+1], h};
                pos += sz;
            end
        end
        exp_q.push_back(e);
        if (rst || fl) begin
            mq.delete();
        end else begin
            if (ir) repeat (pos) void'(mq.pop_front());
            if (pv && e.rdy) begin
                for (int j = int'(off); j < DW; j++) mq.push_back(pkt[j*16 +: 16]);
            end
        end
    endtask

    task automatic idle(input int n, input logic ir);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 3'd0, ir);
    endtask

    function automatic logic [127:0] rand_pkt();
        logic [127:0] p;
        logic [15:0]  h;
        for (int j = 0; j < DW; j++) begin
            h = 16'($urandom);
            if ($urandom_range(1, 0) == 1) h[1:0] = 2'b11;
            else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
            p[j*16 +: 16] = h;
        end
        return p;
    endfunction

    // Monitor: every presented cycle is popped from the scoreboard and compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("packet_ready", 32'(o_packet_ready), 32'(e.rdy));
                chk("inst_valid", 32'(o_inst_valid), 32'(e.v));
                chk("compressed", 32'(o_compressed), 32'(e.c));
                for (int k = 0; k < ISSUE; k++) begin
                    if (e.v[k]) chk($sformatf("lane%0d", k), o_inst[k*32 +: 32], e.inst[k*32 +: 32]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] p;
        i_rst = 1'b1; i_flush = 1'b0; i_packet_valid = 1'b0;
        i_packet = '0; i_offset = '0; i_inst_ready = 1'b0;

        // Reset, then first cycle out of reset must report ready.
        step(1'b1, 1'b0, 1'b0, '0, 3'd0, 1'b1);
        step(1'b1, 1'b0, 1'b0, '0, 3'd0, 1'b1);

        // Eight compressed halfwords: two full issue groups, then empty.
        step(1'b0, 1'b0, 1'b1, {8{16'h0001}}, 3'd0, 1'b1);
        idle(3, 1'b1);

        // Straddled addi: upper half arrives a cycle late.
        step(1'b0, 1'b0, 1'b1, {16'h0013, {7{16'h0001}}}, 3'd0, 1'b1);
        idle(2, 1'b1);
        step(1'b0, 1'b0, 1'b1, {{7{16'h0001}}, 16'h0000}, 3'd0, 1'b1);
        idle(4, 1'b1);

        // Redirect offset into the packet.
        step(1'b0, 1'b0, 1'b1, rand_pkt(), 3'd3, 1'b1);
        idle(4, 1'b1);

        // Backpressure: fill until ready drops, then drain in order.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, rand_pkt(), 3'd0, 1'b0);
        idle(12, 1'b1);

        // Flush with a half-buffered 32-bit instruction and a competing packet.
        step(1'b0, 1'b0, 1'b1, {16'h0013, {7{16'h0001}}}, 3'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, rand_pkt(), 3'd0, 1'b1);
        step(1'b0, 1'b0, 1'b1, rand_pkt(), 3'd0, 1'b1);
        idle(4, 1'b1);

        // Reset mid-stream, then release.
        step(1'b0, 1'b0, 1'b1, rand_pkt(), 3'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, rand_pkt(), 3'd1, 1'b0);
        step(1'b1, 1'b0, 1'b1, rand_pkt(), 3'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, 3'd0, 1'b1);
        idle(2, 1'b1);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            p = rand_pkt();
            step(($urandom_range(79, 0) == 0), ($urandom_range(24, 0) == 0),
                 ($urandom_range(3, 0) != 0), p, 3'($urandom_range(7, 0)),
                 ($urandom_range(3, 0) != 0));
        end
        idle(12, 1'b1);

        @(negedge clk);
        @(negedge clk);
        #3;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
